fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 32 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and the reusable round-robin picker.
// Optional statistics counters in the top are enabled with FIFO_ARB_STATS_EN.
package fifo_wr_arbiter_pkg;

    localparam int DATA_W_DEF = 362;
    localparam int RR_MAX     = 16;
    localparam int RR_IDX_W   = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Returns {found, index}: the first set request after ptr, wrapping modulo n.
    function automatic logic [RR_IDX_W:0] rr_first(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  n
    );
        logic [RR_IDX_W:0] r;
        int                idx;
        r = '0;
        for (int i = 1; i <= RR_MAX; i++) begin
            if (i <= n && !r[RR_IDX_W]) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx]) r = {1'b1, idx[RR_IDX_W-1:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: request vector + last-served pointer -> one-hot grant + index.
// Shared with the read-side scheduler; holds no state.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_oh_o,
    output logic [IDW-1:0] gnt_idx_o
);

    logic [RR_MAX-1:0]   req_pad;
    logic [RR_IDX_W-1:0] ptr_pad;
    logic [RR_IDX_W:0]   pick;

    always_comb begin
        req_pad          = '0;
        req_pad[N-1:0]   = req_i;
        ptr_pad          = '0;
        ptr_pad[IDW-1:0] = ptr_i;
        pick             = rr_first(req_pad, ptr_pad, N);
        gnt_oh_o         = '0;
        for (int k = 0; k < N; k++) begin
            gnt_oh_o[k] = pick[RR_IDX_W] && (pick[RR_IDX_W-1:0] == RR_IDX_W'(k));
        end
        gnt_idx_o = pick[IDW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter feeding one FWFT FIFO write port through a single output register.
// Define FIFO_ARB_STATS_EN to add per-requester beat counters and a stall-cycle counter.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ-1:0]        i_req_last,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_fifo_w_en,
    output logic [DATA_W-1:0]       o_fifo_data,
    output logic [ID_W-1:0]         o_fifo_src,
    input  logic                    i_fifo_full,
    input  logic                    i_fifo_almost_full,
    output logic [ID_W-1:0]         o_owner,
    output logic                    o_busy,
    output logic                    o_err
`ifdef FIFO_ARB_STATS_EN
   ,output logic [N_REQ*32-1:0]     o_stat_beats,
    output logic [31:0]             o_stat_stall
`endif
);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               w_en_q;
    logic [DATA_W-1:0]  data_q;
    logic [ID_W-1:0]    src_q;
    logic               err_q;

    logic               space;
    logic [N_REQ-1:0]   gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic [N_REQ-1:0]   accept;
    logic               acc_any;
    logic [ID_W-1:0]    acc_idx;
    logic               acc_last;
    logic [DATA_W-1:0]  acc_data;

    assign space = !i_fifo_full && !i_fifo_almost_full;

    rr_pick #(.N(N_REQ), .IDW(ID_W)) u_pick (
        .req_i     (i_req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    // Only one ready bit can ever be set, so accept is one-hot or zero.
    always_comb begin
        o_req_ready = '0;
        acc_idx     = owner_q;
        if (state_q == ST_IDLE) begin
            o_req_ready = gnt_oh & {N_REQ{space}};
            acc_idx     = gnt_idx;
        end else begin
            o_req_ready[owner_q] = space;
        end
        accept   = i_req_valid & o_req_ready;
        acc_any  = |accept;
        acc_last = i_req_last[acc_idx];
        acc_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (acc_idx == ID_W'(k)) acc_data = i_req_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (acc_any) begin
            if (state_q == ST_IDLE) begin
                owner_d = gnt_idx;
                if (acc_last) rr_ptr_d = gnt_idx;
                else          state_d  = ST_LOCKED;
            end else if (acc_last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = owner_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= ID_W'(N_REQ - 1);
            owner_q  <= '0;
            w_en_q   <= 1'b0;
            data_q   <= '0;
            src_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            w_en_q   <= acc_any;
            if (acc_any) begin
                data_q <= acc_data;
                src_q  <= acc_idx;
            end
            // A write landing on a full FIFO means the flags upstream lied.
            if (w_en_q && i_fifo_full) err_q <= 1'b1;
        end
    end

    assign o_fifo_w_en = w_en_q;
    assign o_fifo_data = data_q;
    assign o_fifo_src  = src_q;
    assign o_owner     = owner_q;
    assign o_busy      = (state_q == ST_LOCKED);
    assign o_err       = err_q;

`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] stat_beats_q;
    logic [31:0]            stat_stall_q;
    logic                   stalled;

    // A stall is a requester that would be served if the FIFO had room.
    assign stalled = !space && ((state_q == ST_IDLE) ? (|i_req_valid) : i_req_valid[owner_q]);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (accept[k]) stat_beats_q[k] <= stat_beats_q[k] + 32'd1;
            end
            if (stalled && stat_stall_q != 32'hFFFF_FFFF) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign o_stat_beats = stat_beats_q;
    assign o_stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin, packet lock, backpressure, reset, error flag, 128-deep FIFO flood.
module tb_fifo_wr_arbiter;

    localparam int DATA_W = 362;
    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
    localparam int DEPTH  = 128;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_w_en;
    logic [DATA_W-1:0]       fifo_data;
    logic [ID_W-1:0]         fifo_src;
    logic                    fifo_full;
    logic                    fifo_af;
    logic [ID_W-1:0]         owner;
    logic                    busy;
    logic                    err;

    logic                    tb_full;
    logic                    tb_af;
    logic                    model_en;
    int                      wcount;
    logic [ID_W-1:0]         mem [DEPTH];

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req_valid        (req_valid),
        .i_req_last         (req_last),
        .i_req_data         (req_data),
        .o_req_ready        (req_ready),
        .o_fifo_w_en        (fifo_w_en),
        .o_fifo_data        (fifo_data),
        .o_fifo_src         (fifo_src),
        .i_fifo_full        (fifo_full),
        .i_fifo_almost_full (fifo_af),
        .o_owner            (owner),
        .o_busy             (busy),
        .o_err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO with almost-full at DEPTH-1 entries; used only for the flood test.
    assign fifo_full = model_en ? (wcount >= DEPTH)     : tb_full;
    assign fifo_af   = model_en ? (wcount >= DEPTH - 1) : tb_af;

    always @(posedge clk) begin
        if (model_en && fifo_w_en) begin
            if (wcount < DEPTH) mem[wcount] <= fifo_src;
            wcount <= wcount + 1;
        end
    end

    function automatic logic [DATA_W-1:0] mk(input int k, input int seq);
        logic [DATA_W-1:0] d;
        d = '0;
        d[15:0]            = 16'(seq);
        d[19:16]           = 4'(k);
        d[DATA_W-1 -: 16]  = ~16'(seq);
        return d;
    endfunction

    task automatic set_data(input int k, input logic [DATA_W-1:0] d);
        req_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
        tb_full = 1'b0; tb_af = 1'b0; model_en = 1'b0; wcount = 0;
        repeat (2) @(negedge clk);
        chk("rst_wen",   fifo_w_en, 0);
        chk("rst_data",  fifo_data, 0);
        chk("rst_src",   fifo_src, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_err",   err, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ready", req_ready, 0);
        rst_n = 1'b1;

        // Round-robin with single-beat packets
        req_valid = 4'hF; req_last = 4'hF;
        for (int k = 0; k < N_REQ; k++) set_data(k, mk(k, 100 + k));
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_ready", req_ready, 4'b0001 << (i % 4));
            @(negedge clk);
            chk("rr_wen",  fifo_w_en, 1);
            chk("rr_src",  fifo_src, i % 4);
            chk("rr_data", fifo_data, mk(i % 4, 100 + i % 4));
            chk("rr_busy", busy, 0);
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_drain", fifo_w_en, 0);

        // Packet lock: requester 1 sends 3 beats while 2 waits
        req_valid = 4'b0110; req_last = 4'b0000;
        set_data(2, mk(2, 50));
        for (int b = 1; b <= 3; b++) begin
            set_data(1, mk(1, b));
            if (b == 3) req_last = 4'b0010;
            #1 chk("lk_ready", req_ready, 4'b0010);
            @(negedge clk);
            chk("lk_wen",  fifo_w_en, 1);
            chk("lk_src",  fifo_src, 1);
            chk("lk_data", fifo_data, mk(1, b));
            chk("lk_busy", busy, (b < 3) ? 1 : 0);
        end
        req_valid = 4'b0100; req_last = 4'b0100;
        #1 chk("lk_next_ready", req_ready, 4'b0100);
        @(negedge clk);
        chk("lk_next_src",  fifo_src, 2);
        chk("lk_next_data", fifo_data, mk(2, 50));
        req_valid = '0;

        // Backpressure mid-packet from requester 0
        req_valid = 4'b0001; req_last = 4'b0000;
        set_data(0, mk(0, 1));
        #1 chk("bp_ready1", req_ready, 4'b0001);
        @(negedge clk);
        chk("bp_busy", busy, 1);
        set_data(0, mk(0, 2));
        @(negedge clk);
        chk("bp_data2", fifo_data, mk(0, 2));
        set_data(0, mk(0, 3)); set_data(3, mk(3, 7));
        req_valid = 4'b1001; tb_af = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1 chk("bp_stall_ready", req_ready, 0);
            @(negedge clk);
            chk("bp_stall_wen",   fifo_w_en, 0);
            chk("bp_stall_busy",  busy, 1);
            chk("bp_stall_owner", owner, 0);
        end
        tb_af = 1'b0; req_last = 4'b0001;
        #1 chk("bp_resume_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("bp_resume_wen",  fifo_w_en, 1);
        chk("bp_resume_data", fifo_data, mk(0, 3));
        chk("bp_resume_busy", busy, 0);
        req_valid = 4'b1000; req_last = 4'b1000;
        #1 chk("bp_r3_ready", req_ready, 4'b1000);
        @(negedge clk);
        chk("bp_r3_src", fifo_src, 3);
        req_valid = '0;
        @(negedge clk);
        chk("bp_nodup", fifo_w_en, 0);

        // Reset in the middle of a 4-beat packet from requester 3
        req_valid = 4'b1000; req_last = 4'b0000;
        set_data(3, mk(3, 1));
        @(negedge clk);
        set_data(3, mk(3, 2));
        @(negedge clk);
        chk("mr_wen_pre", fifo_w_en, 1);
        chk("mr_busy_pre", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_wen",   fifo_w_en, 0);
        chk("mr_data",  fifo_data, 0);
        chk("mr_src",   fifo_src, 0);
        chk("mr_busy",  busy, 0);
        chk("mr_owner", owner, 0);
        chk("mr_err",   err, 0);
        rst_n = 1'b1;
        req_valid = 4'b1001; req_last = 4'b0001;
        set_data(0, mk(0, 9));
        #1 chk("mr_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("mr_src0",  fifo_src, 0);
        chk("mr_data0", fifo_data, mk(0, 9));
        req_valid = '0;

        // Error flag: full asserted while a write is presented
        req_valid = 4'b0010; req_last = 4'b0010;
        set_data(1, mk(1, 9));
        @(negedge clk);
        chk("er_wen", fifo_w_en, 1);
        req_valid = '0; tb_full = 1'b1;
        #1 chk("er_ready", req_ready, 0);
        @(negedge clk);
        chk("er_set", err, 1);
        tb_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("er_sticky", err, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("er_clear", err, 0);
        rst_n = 1'b1;

        // Flood a 128-deep FIFO with no reads
        model_en = 1'b1;
        req_valid = 4'hF; req_last = 4'hF;
        repeat (200) @(negedge clk);
        chk("ff_count", wcount, DEPTH);
        chk("ff_full",  fifo_full, 1);
        chk("ff_err",   err, 0);
        chk("ff_ready", req_ready, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ID_W'(i % 4)) bad++;
        chk("ff_order", bad, 0);
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
